// File: rtl/saph_pixel_unpack_pkg.sv
// Shared types for the read-side pixel unpacker: format descriptor, ARGB colour and the
// MSB-first bit-replication used to widen narrow channels to 8 bits.
package saph_pixel_unpack_pkg;

    localparam logic [3:0] SAPH_PIXTYPE_ARGB = 4'h0;
    localparam logic [3:0] SAPH_PIXTYPE_RGB  = 4'h1;

    // One channel: bit position inside the pixel and width minus one (1..8 bits).
    typedef struct packed {
        logic [4:0] pos;
        logic [2:0] wm1;
    } chfmt_t;

    // size holds the pixel width minus one (1..32 bits).
    typedef struct packed {
        logic [3:0] cat;
        logic [4:0] size;
        chfmt_t     a;
        chfmt_t     r;
        chfmt_t     g;
        chfmt_t     b;
    } pixfmt_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } color_t;

    // Repeat the low wm1+1 bits of v, MSB first, until 8 bits are filled.
    function automatic logic [7:0] expand8(logic [7:0] v, logic [2:0] wm1);
        logic [7:0] res;
        logic [2:0] k;
        res = '0;
        k   = wm1;
        for (int i = 7; i >= 0; i--) begin
            res[i] = v[k];
            k      = (k == 3'd0) ? wm1 : k - 3'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/saph_pixel_unpack_chan.sv
// Combinational extraction of one channel from a masked pixel, widened to 8 bits.
module saph_chan_expand
    import saph_pixel_unpack_pkg::*;
(
    input  chfmt_t      chfmt_i,
    input  logic [31:0] pixel_i,
    output logic [7:0]  chan_o
);

    logic [7:0] raw;

    // Bits above the channel width are ignored by expand8.
    assign raw    = 8'(pixel_i >> chfmt_i.pos);
    assign chan_o = expand8(raw, chfmt_i.wm1);

endmodule

// File: rtl/saph_pixel_unpack.sv
// Read-path pixel decoder: packs 32-bit words into a bit buffer and pops one ARGB8888 pixel
// per cycle as described by the latched format descriptor.
module saph_pixel_unpack
    import saph_pixel_unpack_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned BUF_W  = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fmt_load_i,
    input  pixfmt_t           fmt_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WORD_W-1:0] in_word_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WORD_W-1:0] out_color_o
);

    localparam int unsigned CntW = $clog2(BUF_W + 1);

    typedef enum logic [0:0] {StUnconf, StRun} state_e;

    state_e            st_q, st_d;
    pixfmt_t           fmt_q, fmt_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    color_t            out_color_q, out_color_d;

    logic [5:0]        shift_s;
    logic              push;
    logic              pop;
    logic [CntW-1:0]   avail;
    logic [BUF_W-1:0]  comb_buf;
    logic [WORD_W-1:0] pix_mask;
    logic [WORD_W-1:0] pixel;
    logic [7:0]        ch_a, ch_r, ch_g, ch_b;
    color_t            pix_color;

    assign shift_s    = {1'b0, fmt_q.size} + 6'd1;
    assign in_ready_o = (st_q == StRun) && (cnt_q <= CntW'(WORD_W)) && !flush_i && !fmt_load_i;
    assign push       = in_valid_i && in_ready_o;

    // An incoming word is visible to the pop logic in the same cycle, giving one-cycle latency.
    assign avail    = push ? cnt_q + CntW'(WORD_W) : cnt_q;
    assign comb_buf = buf_q | (push ? ({{(BUF_W - WORD_W){1'b0}}, in_word_i} << cnt_q) : '0);
    assign pop      = (st_q == StRun) && !flush_i && !fmt_load_i &&
                      (avail >= CntW'(shift_s)) && (!out_valid_q || out_ready_i);

    // Shift by 32 yields zero, so a full-width pixel gets an all-ones mask.
    assign pix_mask = ~({WORD_W{1'b1}} << shift_s);
    assign pixel    = comb_buf[WORD_W-1:0] & pix_mask;

    saph_chan_expand u_exp_a (.chfmt_i(fmt_q.a), .pixel_i(pixel), .chan_o(ch_a));
    saph_chan_expand u_exp_r (.chfmt_i(fmt_q.r), .pixel_i(pixel), .chan_o(ch_r));
    saph_chan_expand u_exp_g (.chfmt_i(fmt_q.g), .pixel_i(pixel), .chan_o(ch_g));
    saph_chan_expand u_exp_b (.chfmt_i(fmt_q.b), .pixel_i(pixel), .chan_o(ch_b));

    always_comb begin
        pix_color = '0;
        if (fmt_q.cat == SAPH_PIXTYPE_ARGB) begin
            pix_color = '{a: ch_a, r: ch_r, g: ch_g, b: ch_b};
        end else if (fmt_q.cat == SAPH_PIXTYPE_RGB) begin
            pix_color = '{a: 8'hFF, r: ch_r, g: ch_g, b: ch_b};
        end
    end

    always_comb begin
        st_d        = st_q;
        fmt_d       = fmt_q;
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_color_d = out_color_q;
        if (fmt_load_i) begin
            st_d        = StRun;
            fmt_d       = fmt_i;
            buf_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            out_color_d = '0;
        end else if (st_q == StRun) begin
            if (flush_i) begin
                buf_d = '0;
                cnt_d = '0;
            end else if (pop) begin
                buf_d = comb_buf >> shift_s;
                cnt_d = avail - CntW'(shift_s);
            end else begin
                buf_d = comb_buf;
                cnt_d = avail;
            end
            if (pop) begin
                out_valid_d = 1'b1;
                out_color_d = pix_color;
            end else if (out_ready_i) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q        <= StUnconf;
            fmt_q       <= '0;
            buf_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_color_q <= '0;
        end else begin
            st_q        <= st_d;
            fmt_q       <= fmt_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_color_q <= out_color_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_color_o = out_color_q;

endmodule
